// File: rtl/sop_sweep_eval.sv
// Registered sum-of-products evaluator: runtime-programmable product terms, single-vector
// evaluation over valid/ready, and an exhaustive sweep that counts 1 outputs.
// Optional SOP_MINTERM_MAP_EN adds a per-minterm result map written during the sweep.
module sop_sweep_eval #(
   parameter int N_IN    = 5,
   parameter int N_TERMS = 3,
   parameter int IDX_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic              cfg_en,
   input  logic [N_IN-1:0]   cfg_care,
   input  logic [N_IN-1:0]   cfg_pol,
   input  logic              in_valid,
   input  logic [N_IN-1:0]   in_vec,
   output logic              in_ready,
   output logic              out_valid,
   output logic              out_val,
   input  logic              sweep_start,
   output logic              sweep_busy,
   output logic              sweep_done,
   output logic [N_IN:0]     ones_count
`ifdef SOP_MINTERM_MAP_EN
   ,
   output logic [2**N_IN-1:0] minterm_map
`endif
);

   localparam logic [0:0]      IDLE  = 1'b0;
   localparam logic [0:0]      SWEEP = 1'b1;
   localparam logic [N_IN-1:0] LAST  = {N_IN{1'b1}};
   localparam logic [IDX_W:0]  SLOTS = N_TERMS[IDX_W:0];

   logic [0:0]         state;
   logic [N_IN-1:0]    counter;
   logic [N_TERMS-1:0] en_q;
   logic [N_IN-1:0]    care_q [N_TERMS];
   logic [N_IN-1:0]    pol_q  [N_TERMS];
   logic [N_TERMS-1:0] term_in;
   logic [N_TERMS-1:0] term_sw;
   logic               f_in;
   logic               f_sw;
   logic               accept;
   logic               cfg_write;

   // Two copies of the term logic: one for the handshake vector, one for the sweep counter.
   for (genvar t = 0; t < N_TERMS; t++) begin : g_term
      assign term_in[t] = en_q[t] & (&(~care_q[t] | ~(in_vec  ^ pol_q[t])));
      assign term_sw[t] = en_q[t] & (&(~care_q[t] | ~(counter ^ pol_q[t])));
   end

   assign f_in       = |term_in;
   assign f_sw       = |term_sw;
   assign sweep_busy = (state == SWEEP);
   assign in_ready   = ~sweep_busy;
   assign accept     = in_valid & in_ready;
   assign cfg_write  = cfg_we & ~sweep_busy & ({1'b0, cfg_idx} < SLOTS);

   // Term slots; evaluation this cycle always sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q <= '0;
         for (int t = 0; t < N_TERMS; t++) begin
            care_q[t] <= '0;
            pol_q[t]  <= '0;
         end
      end else if (cfg_write) begin
         en_q[cfg_idx]   <= cfg_en;
         care_q[cfg_idx] <= cfg_care;
         pol_q[cfg_idx]  <= cfg_pol;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_val   <= 1'b0;
      end else begin
         out_valid <= accept;
         if (accept) begin
            out_val <= f_in;
         end
      end
   end

   // Sweep FSM: the done pulse is registered on the same edge that returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         counter    <= '0;
         ones_count <= '0;
         sweep_done <= 1'b0;
      end else begin
         sweep_done <= 1'b0;
         case (state)
            IDLE: begin
               if (sweep_start) begin
                  state      <= SWEEP;
                  counter    <= '0;
                  ones_count <= '0;
               end
            end
            SWEEP: begin
               ones_count <= ones_count + {{N_IN{1'b0}}, f_sw};
               counter    <= counter + 1'b1;
               if (counter == LAST) begin
                  state      <= IDLE;
                  sweep_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SOP_MINTERM_MAP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         minterm_map <= '0;
      end else if (state == IDLE && sweep_start) begin
         minterm_map <= '0;
      end else if (state == SWEEP) begin
         minterm_map[counter] <= f_sw;
      end
   end
`endif

endmodule
